alu_muldiv_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer for the RISC-V single-cycle core's M-extension path.
- Acts as the initiator toward the shared 32-bit ALU: it drives the ALU's operands and control each cycle, and consumes the ALU's sum result and carry to iterate.
- Shift-add multiply and restoring divide, 32 iterations each.
- Valid/ready request and response handshakes toward the execute stage.

---
 rtl/alu_muldiv_seq_if.sv | 29 ++
 rtl/alu_muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU signal bundle for the multiply/divide sequencer.
// The sequencer uses the slave modport; the execute stage and ALU use the master side.
interface alu_muldiv_seq_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_zero;
  logic            resp_dbz;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  logic            alu_carry;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_carry,
    output req_ready, resp_valid, resp_data, resp_zero, resp_dbz, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_carry,
    input  req_ready, resp_valid, resp_data, resp_zero, resp_dbz, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned shift-add multiply / restoring divide sequencer driving the shared 32-bit ALU.
// Optional macro ZERO_SKIP_EN: MUL/MULHU with a zero operand completes without iterating.
module alu_muldiv_seq #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_seq_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [ITER_W-1:0] CNT_INIT = ITER_W'(XLEN);
  localparam logic [ITER_W-1:0] CNT_LAST = ITER_W'(1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            dbz_q, dbz_d;

  logic            c;
  logic [XLEN-1:0] s;
  logic [XLEN-1:0] t;
  logic            take;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dbz_d   = dbz_q;
    c       = 1'b0;
    s       = '0;
    t       = '0;
    take    = 1'b0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          b_d   = bus.req_b;
          hi_d  = '0;
          lo_d  = bus.req_a;
          rem_d = '0;
          cnt_d = CNT_INIT;
          dbz_d = 1'b0;
          if (bus.req_op[1] && (bus.req_b == '0)) begin
            state_d = S_DONE;
            dbz_d   = 1'b1;
            data_d  = (bus.req_op == OP_DIVU) ? {XLEN{1'b1}} : bus.req_a;
          end
`ifdef ZERO_SKIP_EN
          else if (!bus.req_op[1] && ((bus.req_a == '0) || (bus.req_b == '0))) begin
            state_d = S_DONE;
            data_d  = '0;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CNT_LAST;
        if (!op_q[1]) begin
          bus.alu_a    = hi_q;
          bus.alu_b    = b_q;
          bus.alu_ctrl = ALU_ADD;
          if (lo_q[0]) begin
            c = bus.alu_carry;
            s = bus.alu_result;
          end else begin
            c = 1'b0;
            s = hi_q;
          end
          hi_d = {c, s[XLEN-1:1]};
          lo_d = {s[0], lo_q[XLEN-1:1]};
        end else begin
          // rem[31] is the 33rd remainder bit; when set the shifted value always exceeds b
          t            = {rem_q[XLEN-2:0], lo_q[XLEN-1]};
          bus.alu_a    = t;
          bus.alu_b    = b_q;
          bus.alu_ctrl = ALU_SUB;
          take         = rem_q[XLEN-1] | bus.alu_carry;
          rem_d        = take ? bus.alu_result : t;
          lo_d         = {lo_q[XLEN-2:0], take};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL, OP_DIVU: data_d = lo_d;
            OP_MULHU:        data_d = hi_d;
            default:         data_d = rem_d;
          endcase
        end
      end

      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = data_q;
  assign bus.resp_zero  = (data_q == '0);
  assign bus.resp_dbz   = dbz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: vector table, random ops, and handshake/reset corners.
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_seq_if bus();

  alu_muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));

  // External ALU model: add with carry-out, subtract with carry = (a >= b)
  logic [32:0] add_w;
  assign add_w          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_result = (bus.alu_ctrl == 3'b001) ? (bus.alu_a - bus.alu_b) : add_w[31:0];
  assign bus.alu_carry  = (bus.alu_ctrl == 3'b001) ? (bus.alu_a >= bus.alu_b) : add_w[32];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] b;
    logic [31:0] data;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[1] && b == 0) return 1;
`ifdef ZERO_SKIP_EN
    if (!op[1] && (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic dbz);
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    e.op = op; e.b = b; e.data = exp; e.dbz = dbz; e.lat = exp_lat(op, a, b);
    sb.push_back(e);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_resp();
    int   lat;
    exp_t e;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      if (lat == 1 && sb.size() > 0) begin
        chk("alu_ctrl_run", {29'b0, bus.alu_ctrl}, sb[0].op[1] ? 32'd1 : 32'd0);
        chk("alu_b_run", bus.alu_b, sb[0].b);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("resp_data", bus.resp_data, e.data);
      chk("resp_zero", {31'b0, bus.resp_zero}, {31'b0, (e.data == 0)});
      chk("resp_dbz", {31'b0, bus.resp_dbz}, {31'b0, e.dbz});
    end
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("valid_drop", {31'b0, bus.resp_valid}, 32'd0);
    chk("ready_back", {31'b0, bus.req_ready}, 32'd1);
  endtask

  task automatic no_resp(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = '{2'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0};
    vt[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[2]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vt[3]  = '{2'd2, 32'd100,       32'd7,         32'd14,        1'b0};
    vt[4]  = '{2'd3, 32'd100,       32'd7,         32'd2,         1'b0};
    vt[5]  = '{2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 1'b0};
    vt[6]  = '{2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0};
    vt[7]  = '{2'd2, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vt[8]  = '{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1};
    vt[9]  = '{2'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vt[10] = '{2'd1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[11] = '{2'd2, 32'd5,         32'd9,         32'd0,         1'b0};
    vt[12] = '{2'd3, 32'h8000_0000, 32'd3,         32'd2,         1'b0};
    vt[13] = '{2'd1, 32'h8000_0000, 32'd2,         32'd1,         1'b0};

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'd0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_zero", {31'b0, bus.resp_zero}, 32'd1);
    chk("rst_resp_dbz", {31'b0, bus.resp_dbz}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      start(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].dbz);
      wait_resp();
      release_resp();
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      start(op, a, b, model(op, a, b), op[1] && (b == 0));
      wait_resp();
      release_resp();
    end

    // Backpressure: result held, further requests ignored while DONE
    start(2'd2, 32'd100, 32'd7, 32'd14, 1'b0);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'd0;
      bus.req_a     = 32'd3;
      bus.req_b     = 32'd3;
      chk("hold_data", bus.resp_data, 32'd14);
      chk("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    release_resp();
    no_resp("ignored_req_no_resp", 40);

    // Abort in the middle of an operation
    start(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("abort_resp_data", bus.resp_data, 32'd0);
    chk("abort_alu_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_resp("abort_no_resp", 40);

    start(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
    wait_resp();
    release_resp();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
